// File: rtl/pe_array_sequencer.sv
// Control sequencer for a linear chain of processing elements: loads one weight per PE,
// streams samples into PE0 and sums the registered PE products into one result per sample.
module pe_array_sequencer #(
    parameter int NUM_PE = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    parameter int RES_W  = 2*DATA_W + $clog2(NUM_PE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_samples,
    input  logic                 w_valid,
    input  logic [DATA_W-1:0]    w_data,
    output logic                 w_ready,
    input  logic                 d_valid,
    input  logic [DATA_W-1:0]    d_data,
    output logic                 d_ready,
    output logic                 pe_enable,
    output logic [NUM_PE-1:0]    pe_read_weight,
    output logic                 pe_read_data,
    output logic [NUM_PE-1:0]    pe_forwarding_enable,
    output logic [DATA_W-1:0]    weight_bus,
    output logic [DATA_W-1:0]    data_bus,
    input  logic [16*NUM_PE-1:0] pe_products,
    output logic                 res_valid,
    output logic [RES_W-1:0]     res_data,
    output logic                 busy,
    output logic                 done
);

    localparam int WC_W = $clog2(NUM_PE);
    localparam logic [NUM_PE-1:0] FWD_ONES = {{(NUM_PE-1){1'b1}}, 1'b0};
    localparam logic [NUM_PE-1:0] ONE_HOT0 = NUM_PE'(1);

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, FLUSH, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] nsamp;
    logic [CNT_W-1:0] scnt;
    logic [WC_W-1:0]  wcnt;
    logic             stepping;
    logic             primed;
    logic             res_pend;
    logic [RES_W-1:0] prod_sum;

    assign w_ready = (state == LOAD_W);
    assign d_ready = (state == STREAM);
    assign busy    = (state != IDLE);

    always_comb begin
        prod_sum = '0;
        for (int unsigned k = 0; k < NUM_PE; k++)
            prod_sum = prod_sum + RES_W'(pe_products[16*k +: 16]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= IDLE;
            nsamp                <= '0;
            scnt                 <= '0;
            wcnt                 <= '0;
            stepping             <= 1'b0;
            primed               <= 1'b0;
            res_pend             <= 1'b0;
            pe_enable            <= 1'b0;
            pe_read_weight       <= '0;
            pe_read_data         <= 1'b0;
            pe_forwarding_enable <= '0;
            weight_bus           <= '0;
            data_bus             <= '0;
            res_valid            <= 1'b0;
            res_data             <= '0;
            done                 <= 1'b0;
        end else begin
            pe_enable      <= 1'b0;
            pe_read_weight <= '0;
            pe_read_data   <= 1'b0;
            stepping       <= 1'b0;
            done           <= 1'b0;

            // stepping marks a step edge; the first step only primes the pipeline,
            // every later one yields a result one edge after it
            res_pend  <= stepping & primed;
            res_valid <= res_pend;
            if (stepping)
                primed <= 1'b1;
            if (res_pend)
                res_data <= prod_sum;

            case (state)
                IDLE: begin
                    if (start) begin
                        nsamp  <= num_samples;
                        wcnt   <= '0;
                        scnt   <= '0;
                        primed <= 1'b0;
                        state  <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (w_valid) begin
                        weight_bus     <= w_data;
                        pe_read_weight <= ONE_HOT0 << wcnt;
                        pe_enable      <= 1'b1;
                        wcnt           <= wcnt + 1'b1;
                        if (wcnt == WC_W'(NUM_PE-1)) begin
                            if (nsamp == '0) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                state <= STREAM;
                            end
                        end
                    end
                end
                STREAM: begin
                    if (d_valid) begin
                        data_bus             <= d_data;
                        pe_read_data         <= 1'b1;
                        pe_forwarding_enable <= FWD_ONES;
                        pe_enable            <= 1'b1;
                        stepping             <= 1'b1;
                        scnt                 <= scnt + 1'b1;
                        if (scnt == nsamp - 1'b1)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    pe_enable            <= 1'b1;
                    pe_forwarding_enable <= FWD_ONES;
                    stepping             <= 1'b1;
                    state                <= FLUSH;
                end
                FLUSH: begin
                    pe_forwarding_enable <= '0;
                    done                 <= 1'b1;
                    state                <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Directed bench for pe_array_sequencer with a behavioural PE chain model
// (per PE: input register, forwarding register, registered product of weight and input).
module tb_pe_array_sequencer;

    localparam int NUM_PE = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;
    localparam int RES_W  = 18;
    localparam logic [NUM_PE-1:0] FWD = 4'b1110;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [CNT_W-1:0]     num_samples = '0;
    logic                 w_valid = 1'b0;
    logic [DATA_W-1:0]    w_data = '0;
    logic                 w_ready;
    logic                 d_valid = 1'b0;
    logic [DATA_W-1:0]    d_data = '0;
    logic                 d_ready;
    logic                 pe_enable;
    logic [NUM_PE-1:0]    pe_read_weight;
    logic                 pe_read_data;
    logic [NUM_PE-1:0]    pe_forwarding_enable;
    logic [DATA_W-1:0]    weight_bus;
    logic [DATA_W-1:0]    data_bus;
    logic [16*NUM_PE-1:0] pe_products;
    logic                 res_valid;
    logic [RES_W-1:0]     res_data;
    logic                 busy;
    logic                 done;

    pe_array_sequencer #(.NUM_PE(NUM_PE), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .d_valid(d_valid), .d_data(d_data), .d_ready(d_ready),
        .pe_enable(pe_enable), .pe_read_weight(pe_read_weight),
        .pe_read_data(pe_read_data), .pe_forwarding_enable(pe_forwarding_enable),
        .weight_bus(weight_bus), .data_bus(data_bus), .pe_products(pe_products),
        .res_valid(res_valid), .res_data(res_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // PE chain model
    logic [DATA_W-1:0] m_w   [NUM_PE];
    logic [DATA_W-1:0] m_in  [NUM_PE];
    logic [DATA_W-1:0] m_out [NUM_PE];
    logic [15:0]       m_prod[NUM_PE];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_PE; k++) begin
                m_w[k] <= '0; m_in[k] <= '0; m_out[k] <= '0; m_prod[k] <= '0;
            end
        end else if (pe_enable) begin
            if (pe_read_data) m_in[0] <= data_bus;
            for (int k = 1; k < NUM_PE; k++)
                if (pe_forwarding_enable[k]) m_in[k] <= m_out[k-1];
            for (int k = 0; k < NUM_PE; k++) begin
                if (pe_read_weight[k]) m_w[k] <= weight_bus;
                m_out[k]  <= m_in[k];
                m_prod[k] <= {8'b0, m_w[k]} * {8'b0, m_in[k]};
            end
        end
    end

    always_comb begin
        pe_products = '0;
        for (int k = 0; k < NUM_PE; k++) pe_products[16*k +: 16] = m_prod[k];
    end

    // Output monitor
    int cyc = 0, done_cnt = 0, done_cyc = 0, fall_cyc = 0, dr_cnt = 0, rd_cnt = 0, fwd_bad = 0;
    logic prev_busy = 1'b0;
    logic [RES_W-1:0]  res_q[$];
    int                rw_cyc_q[$];
    logic [NUM_PE-1:0] rw_val_q[$];
    logic [DATA_W-1:0] rw_bus_q[$];
    logic              rw_en_q[$];

    always @(negedge clk) begin
        cyc++;
        if (res_valid) res_q.push_back(res_data);
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (prev_busy && !busy) fall_cyc = cyc;
        prev_busy = busy;
        if (|pe_read_weight) begin
            rw_cyc_q.push_back(cyc); rw_val_q.push_back(pe_read_weight);
            rw_bus_q.push_back(weight_bus); rw_en_q.push_back(pe_enable);
        end
        if (d_ready) dr_cnt++;
        if (pe_read_data) rd_cnt++;
        if (pe_forwarding_enable[0] || (pe_read_data && pe_forwarding_enable != FWD)) fwd_bad++;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0][7:0]  w;
        int               n;
        logic [7:0][7:0]  x;
        logic [7:0][17:0] r;
        int               stall;
        bit               poke;
    } job_t;

    job_t jobs[7];

    task automatic set_job(input int j, input logic [31:0] w, input int n, input logic [63:0] x,
                           input logic [143:0] r, input int stall, input bit poke);
        jobs[j].w = w; jobs[j].n = n; jobs[j].x = x; jobs[j].r = r;
        jobs[j].stall = stall; jobs[j].poke = poke;
    endtask

    task automatic do_reset();
        start = 0; w_valid = 0; d_valid = 0;
        rst = 1;
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic start_job(input int n);
        num_samples = CNT_W'(n);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic load_weights(input int j);
        bit acc; int c;
        for (int i = 0; i < NUM_PE; i++) begin
            w_valid = 1; w_data = jobs[j].w[i];
            if (jobs[j].poke && i == 2) begin start = 1; num_samples = 5; end
            acc = 0; c = 0;
            while (!acc && c < 50) begin
                @(negedge clk); acc = w_ready; @(posedge clk); #1; c++;
            end
            start = 0;
            check("w_accept", acc, 1);
        end
        w_valid = 0;
    endtask

    task automatic send_data(input int j, input int cnt);
        bit acc; int c;
        for (int i = 0; i < cnt; i++) begin
            d_valid = 1; d_data = jobs[j].x[i];
            acc = 0; c = 0;
            while (!acc && c < 50) begin
                @(negedge clk); acc = d_ready; @(posedge clk); #1; c++;
            end
            check("d_accept", acc, 1);
            if (i == 0 && jobs[j].stall > 0) begin
                d_valid = 0;
                for (int s = 0; s < jobs[j].stall; s++) begin
                    @(negedge clk);
                    check(s == 0 ? "step1_enable" : "stall_enable", pe_enable, s == 0 ? 1 : 0);
                    @(posedge clk); #1;
                end
            end
        end
        d_valid = 0;
    endtask

    task automatic run_job(input int j, input bit with_reset);
        int rb, db, wb, drb, rdb, nres, nw, c, diff;
        logic [NUM_PE-1:0] oh;
        if (with_reset) do_reset();
        @(posedge clk); #1;
        rb = res_q.size(); db = done_cnt; wb = rw_cyc_q.size(); drb = dr_cnt; rdb = rd_cnt;
        start_job(jobs[j].n);
        load_weights(j);
        send_data(j, jobs[j].n);
        c = 0;
        while (busy && c < 300) begin @(negedge clk); c++; end
        check("job_end", busy, 0);
        repeat (3) @(negedge clk);

        nw = rw_cyc_q.size() - wb;
        check("w_strobe_count", nw, NUM_PE);
        for (int i = 0; i < NUM_PE && i < nw; i++) begin
            oh = 4'b0001 << i;
            check("w_strobe_onehot", rw_val_q[wb+i], oh);
            check("weight_bus", rw_bus_q[wb+i], jobs[j].w[i]);
            check("w_strobe_enable", rw_en_q[wb+i], 1);
            if (i > 0) check("w_strobe_spacing", rw_cyc_q[wb+i] - rw_cyc_q[wb+i-1], 1);
        end

        nres = res_q.size() - rb;
        check("res_count", nres, jobs[j].n);
        for (int i = 0; i < jobs[j].n && i < nres; i++)
            check("res_data", res_q[rb+i], jobs[j].r[i]);
        check("done_count", done_cnt - db, 1);
        check("busy_falls_after_done", fall_cyc - done_cyc, 1);

        if (jobs[j].n == 0) begin
            check("zero_d_ready", dr_cnt - drb, 0);
            check("zero_read_data", rd_cnt - rdb, 0);
            diff = done_cyc - rw_cyc_q[rw_cyc_q.size()-1];
            check("zero_done_after_strobe", (diff >= 0 && diff <= 1), 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int db;
        set_job(0, {8'd4,8'd3,8'd2,8'd1}, 3, {8'd0,8'd0,8'd0,8'd0,8'd0,8'd30,8'd20,8'd10},
                {18'd0,18'd0,18'd0,18'd0,18'd0,18'd50,18'd20,18'd10}, 0, 0);
        set_job(1, {8'd4,8'd3,8'd2,8'd1}, 3, {8'd0,8'd0,8'd0,8'd0,8'd0,8'd30,8'd20,8'd10},
                {18'd0,18'd0,18'd0,18'd0,18'd0,18'd50,18'd20,18'd10}, 3, 0);
        set_job(2, {8'd4,8'd3,8'd2,8'd1}, 3, {8'd0,8'd0,8'd0,8'd0,8'd0,8'd30,8'd20,8'd10},
                {18'd0,18'd0,18'd0,18'd0,18'd0,18'd50,18'd20,18'd10}, 0, 1);
        set_job(3, {8'd4,8'd3,8'd2,8'd1}, 7, {8'd0,8'd7,8'd6,8'd5,8'd4,8'd3,8'd2,8'd1},
                {18'd0,18'd30,18'd20,18'd14,18'd8,18'd5,18'd2,18'd1}, 0, 0);
        set_job(4, {8'd255,8'd255,8'd255,8'd255}, 7,
                {8'd0,8'd255,8'd255,8'd255,8'd255,8'd255,8'd255,8'd255},
                {18'd0,18'd260100,18'd195075,18'd195075,18'd130050,18'd130050,18'd65025,18'd65025}, 0, 0);
        set_job(5, {8'd4,8'd3,8'd2,8'd1}, 1, {8'd0,8'd0,8'd0,8'd0,8'd0,8'd0,8'd0,8'd9},
                {18'd0,18'd0,18'd0,18'd0,18'd0,18'd0,18'd0,18'd9}, 0, 0);
        set_job(6, {8'd4,8'd3,8'd2,8'd1}, 0, '0, '0, 0, 0);

        @(negedge clk);
        check("reset_outputs", {w_ready, d_ready, pe_enable, pe_read_weight, pe_read_data,
              pe_forwarding_enable, weight_bus, data_bus, res_valid, res_data, busy, done}, 0);

        for (int j = 0; j < 7; j++) run_job(j, 1);

        // Abort mid-stream, then a fresh job without any extra reset
        do_reset();
        @(posedge clk); #1;
        start_job(3);
        load_weights(0);
        send_data(0, 1);
        db = done_cnt;
        repeat (2) @(posedge clk);
        #3 rst = 1;
        @(negedge clk);
        check("midrst_outputs", {w_ready, d_ready, pe_enable, pe_read_weight, pe_read_data,
              pe_forwarding_enable, weight_bus, data_bus, res_valid, res_data, busy, done}, 0);
        @(posedge clk); #1;
        rst = 0;
        repeat (6) @(negedge clk);
        check("midrst_no_done", done_cnt - db, 0);
        check("midrst_idle", busy, 0);
        run_job(0, 0);

        check("fwd_bits", fwd_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pe_array_sequencer.md
Name: pe_array_sequencer

Overview:
- Drives a linear chain of NUM_PE processing elements: PE0 takes data_bus; PE k>0 forwards from PE k-1.
- Per job: loads one weight per PE, streams samples into PE0, then adds the registered 16-bit products of all PEs into one result per sample.
- Sits between the host-side weight/data streams and the PE array. It owns every PE control strobe: enable, read_weight, read_data and forwarding_enable.

Parameters:
- NUM_PE, 4, number of PEs in the chain (2..16)
- DATA_W, 8, width of weight_bus/data_bus
- CNT_W, 16, width of num_samples and internal counters
- RES_W, 2*DATA_W+$clog2(NUM_PE), result width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin job; sampled only in IDLE
- num_samples  in  CNT_W  samples in job; latched on start
- w_valid  in  1  weight stream valid
- w_data  in  DATA_W  weight value
- w_ready  out  1  weight accepted when w_valid&w_ready
- d_valid  in  1  data stream valid
- d_data  in  DATA_W  sample value
- d_ready  out  1  sample accepted when d_valid&d_ready
- pe_enable  out  1  enable to all PEs
- pe_read_weight  out  NUM_PE  one-hot weight load strobe per PE
- pe_read_data  out  1  read_data of PE0
- pe_forwarding_enable  out  NUM_PE  forwarding_enable per PE; bit 0 always 0
- weight_bus  out  DATA_W  shared weight bus
- data_bus  out  DATA_W  data bus to PE0
- pe_products  in  16*NUM_PE  product_output of PE k at bits [16k+15:16k]
- res_valid  out  1  one-cycle result strobe; no backpressure
- res_data  out  RES_W  sum of all PE products
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at job end

Behaviour:
- Reset: state IDLE. All outputs are 0, including weight_bus, data_bus, res_data and both readies. Counters are cleared.
- Reset mid-job aborts the job immediately. No done pulse is produced. PE contents are not cleared by this block.
- All PE-facing outputs are registered. A handshake accepted at edge E drives its outputs in the cycle after E. The PEs sample them at the next edge, called the "step edge".
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, FLUSH, DONE.
- IDLE:
  - start=1 latches num_samples, sets wcnt=0 and goes to LOAD_W.
  - start in any other state is ignored.
- LOAD_W:
  - w_ready=1.
  - On accept: weight_bus<=w_data, pe_read_weight<=(1<<wcnt), pe_enable<=1, then wcnt++.
  - After accept NUM_PE-1: go to STREAM, or to DONE if num_samples==0.
  - Cycles without an accept drive pe_enable=0 and pe_read_weight=0.
- STREAM:
  - d_ready=1.
  - On accept: data_bus<=d_data, pe_read_data<=1, pe_forwarding_enable<={ones,0}, pe_enable<=1. This issues a step.
  - When d_valid=0 the next cycle has pe_enable=0, which freezes the whole array; data_bus holds its last value.
  - After num_samples accepts: go to DRAIN.
- DRAIN: issues one extra step with pe_enable=1, pe_read_data=0, forwarding ones and d_ready=0. Next state is FLUSH.
- FLUSH: one idle cycle so the last product lands. Next state is DONE.
- DONE: done=1 for one cycle, then IDLE.
- Results:
  - Steps are numbered s=1..num_samples+1, with the DRAIN step as the last.
  - At the clock edge after step edge s, for s>=2: res_data<=zero-extended sum of the NUM_PE products, and res_valid<=1 for one cycle.
  - This gives exactly num_samples results per job, in order.
  - Back-to-back steps yield back-to-back res_valid.
- Arithmetic: the sum is unsigned, RES_W wide, and never overflows.
- busy=1 from the cycle after start through DONE inclusive.

Test Plan:
- Weight load: NUM_PE=4, weights 1,2,3,4 sent back-to-back. Each pe_read_weight bit is a one-hot pulse in consecutive cycles (0001, 0010, 0100, 1000), weight_bus shows 1,2,3,4 in those cycles, and pe_enable=1 in each.
- Basic job after reset: weights 1,2,3,4, num_samples=3, data 10,20,30, bench PE model attached. Results are 10, 20, 50 in order, then one done pulse with busy falling after it.
- Stall: same job with d_valid low for 3 cycles between samples 1 and 2. pe_enable=0 during the stall, results are still 10, 20, 50, and the result count is 3.
- num_samples=0: after the 4 weight loads, no data_bus step and no res_valid occur. The done pulse follows the last weight strobe, and d_ready never rises.
- Mid-job reset: assert rst during STREAM after sample 1. All outputs go to 0 and the state is IDLE. No done pulse. A new start runs a complete job.
- start ignored while busy: pulse start during LOAD_W. No restart occurs, and the latched num_samples is unchanged.
